// File: rtl/rf_write_arbiter_if.sv
// Bundles the writeback, mul/div, regfile-write and hazard-check signals of the
// register-file write arbiter. The arbiter takes the slave view; the pipeline
// (or a bench) drives through the master view.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              md_valid;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic              stall_req;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              hazard1;
  logic              hazard2;

  modport master (
    output wb_en, wb_addr, wb_data,
    output md_valid, md_addr, md_data,
    output chk_addr1, chk_addr2,
    input  md_ready, rf_we, rf_wa, rf_wd, stall_req, hazard1, hazard2
  );

  modport slave (
    input  wb_en, wb_addr, wb_data,
    input  md_valid, md_addr, md_data,
    input  chk_addr1, chk_addr2,
    output md_ready, rf_we, rf_wa, rf_wd, stall_req, hazard1, hazard2
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. Writeback always wins the port; mul/div
// results wait in a small in-order queue and drain in free slots, bypassing the
// queue when it is empty and the port is idle. A stall request keeps the queue
// from overflowing and stops the queue head from starving behind writeback.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // Queue storage: entry 0 is always the head, valid entries are [0, count).
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve_cnt;

  logic              rf_we_p1;
  logic [ADDR_W-1:0] rf_wa_p1;
  logic [DATA_W-1:0] rf_wd_p1;

  logic              md_ready_p0;
  logic              fifo_empty_p0;
  logic              wb_req_p0;
  logic              md_live_p0;
  logic              sel_pop_p0;
  logic              sel_byp_p0;
  logic              push_p0;
  logic [IDX_W-1:0]  push_idx_p0;
  logic              hazard1_p0;
  logic              hazard2_p0;

  // Grant decision for this cycle: WB first, then queue head, then bypass.
  always_comb begin
    md_ready_p0   = (count < CNT_W'(FIFO_DEPTH));
    fifo_empty_p0 = (count == '0);
    wb_req_p0     = bus.wb_en && (bus.wb_addr != '0);
    // Accepted results addressed to r0 are consumed but never written.
    md_live_p0    = bus.md_valid && md_ready_p0 && (bus.md_addr != '0);
    sel_pop_p0    = !wb_req_p0 && !fifo_empty_p0;
    sel_byp_p0    = !wb_req_p0 && fifo_empty_p0 && md_live_p0;
    push_p0       = md_live_p0 && !sel_byp_p0;
    // On a simultaneous pop the tail slides down one place before the write.
    if (sel_pop_p0) begin
      push_idx_p0 = IDX_W'(count - CNT_W'(1));
    end else begin
      push_idx_p0 = IDX_W'(count);
    end
  end

  // Hazard check against the output stage and every valid queue entry.
  always_comb begin
    hazard1_p0 = (bus.chk_addr1 != '0) && rf_we_p1 && (rf_wa_p1 == bus.chk_addr1);
    hazard2_p0 = (bus.chk_addr2 != '0) && rf_we_p1 && (rf_wa_p1 == bus.chk_addr2);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (i < int'(count)) begin
        if ((bus.chk_addr1 != '0) && (fifo_addr[i] == bus.chk_addr1)) hazard1_p0 = 1'b1;
        if ((bus.chk_addr2 != '0) && (fifo_addr[i] == bus.chk_addr2)) hazard2_p0 = 1'b1;
      end
    end
  end

  // Queue payload: shift toward the head on pop, then write the new tail.
  always_ff @(posedge clk) begin
    if (sel_pop_p0) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        fifo_addr[i] <= fifo_addr[i+1];
        fifo_data[i] <= fifo_data[i+1];
      end
    end
    if (push_p0) begin
      fifo_addr[push_idx_p0] <= bus.md_addr;
      fifo_data[push_idx_p0] <= bus.md_data;
    end
  end

  // Queue occupancy and head-starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push_p0 && !sel_pop_p0) begin
        count <= count + CNT_W'(1);
      end else if (sel_pop_p0 && !push_p0) begin
        count <= count - CNT_W'(1);
      end
      if (!fifo_empty_p0 && !sel_pop_p0) begin
        if (starve_cnt < STV_W'(STARVE_LIMIT)) begin
          starve_cnt <= starve_cnt + STV_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // ---- stage boundary: registered regfile write port ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_p1 <= 1'b0;
      rf_wa_p1 <= '0;
      rf_wd_p1 <= '0;
    end else if (wb_req_p0) begin
      rf_we_p1 <= 1'b1;
      rf_wa_p1 <= bus.wb_addr;
      rf_wd_p1 <= bus.wb_data;
    end else if (sel_pop_p0) begin
      rf_we_p1 <= 1'b1;
      rf_wa_p1 <= fifo_addr[0];
      rf_wd_p1 <= fifo_data[0];
    end else if (sel_byp_p0) begin
      rf_we_p1 <= 1'b1;
      rf_wa_p1 <= bus.md_addr;
      rf_wd_p1 <= bus.md_data;
    end else begin
      rf_we_p1 <= 1'b0;
    end
  end

  assign bus.md_ready  = md_ready_p0;
  assign bus.stall_req = (count == CNT_W'(FIFO_DEPTH)) || (starve_cnt >= STV_W'(STARVE_LIMIT));
  assign bus.rf_we     = rf_we_p1;
  assign bus.rf_wa     = rf_wa_p1;
  assign bus.rf_wd     = rf_wd_p1;
  assign bus.hazard1   = hazard1_p0;
  assign bus.hazard2   = hazard2_p0;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_rf_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int LIMIT  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  // Reference model state
  ent_t              mq[$];
  int                m_starve;
  logic              m_we;
  logic [ADDR_W-1:0] m_wa;
  logic [DATA_W-1:0] m_wd;
  logic              last_stall;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_starve   = 0;
    m_we       = 1'b0;
    m_wa       = '0;
    m_wd       = '0;
    last_stall = 1'b0;
  endfunction

  function automatic logic m_hz(input logic [ADDR_W-1:0] a);
    logic hit;
    hit = m_we && (m_wa == a);
    foreach (mq[i]) if (mq[i].a == a) hit = 1'b1;
    return (a != 0) && hit;
  endfunction

  task automatic set_in(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                        input logic [ADDR_W-1:0] c1, input logic [ADDR_W-1:0] c2);
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.md_valid  = mv;
    bus.md_addr   = ma;
    bus.md_data   = md;
    bus.chk_addr1 = c1;
    bus.chk_addr2 = c2;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check the registered write port just after the edge.
  task automatic cycle();
    int   n;
    logic acc, mdl, wbq, popped;
    ent_t h;
    @(negedge clk);
    n = mq.size();
    chk("md_ready", bus.md_ready, n < DEPTH);
    chk("stall_req", bus.stall_req, (n == DEPTH) || (m_starve >= LIMIT));
    chk("hazard1", bus.hazard1, m_hz(bus.chk_addr1));
    chk("hazard2", bus.hazard2, m_hz(bus.chk_addr2));
    last_stall = (n == DEPTH) || (m_starve >= LIMIT);
    acc    = bus.md_valid && (n < DEPTH);
    mdl    = acc && (bus.md_addr != 0);
    wbq    = bus.wb_en && (bus.wb_addr != 0);
    popped = 1'b0;
    h.a    = bus.md_addr;
    h.d    = bus.md_data;
    if (wbq) begin
      m_we = 1'b1; m_wa = bus.wb_addr; m_wd = bus.wb_data;
      if (mdl) mq.push_back(h);
    end else if (n > 0) begin
      if (mdl) mq.push_back(h);
      h = mq.pop_front();
      m_we = 1'b1; m_wa = h.a; m_wd = h.d;
      popped = 1'b1;
    end else if (mdl) begin
      m_we = 1'b1; m_wa = bus.md_addr; m_wd = bus.md_data;
    end else begin
      m_we = 1'b0;
    end
    if (n > 0 && !popped) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
    else                  m_starve = 0;
    @(posedge clk);
    #1;
    chk("rf_we", bus.rf_we, m_we);
    chk("rf_wa", bus.rf_wa, m_wa);
    chk("rf_wd", bus.rf_wd, m_wd);
  endtask

  task automatic idle();
    set_in(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_we", bus.rf_we, 0);
    chk("rst_wa", bus.rf_wa, 0);
    chk("rst_wd", bus.rf_wd, 0);
    chk("rst_md_ready", bus.md_ready, 1);
    chk("rst_stall", bus.stall_req, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // WB only, then WB to r0 is ignored
    set_in(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, '0, '0, '0, '0);
    cycle();
    chk("wb_we", bus.rf_we, 1);
    chk("wb_wa", bus.rf_wa, 5);
    chk("wb_wd", bus.rf_wd, 32'hA5A5A5A5);
    set_in(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, '0, '0, '0, '0);
    cycle();
    chk("wb_r0_we", bus.rf_we, 0);

    // Bypass into an idle port
    set_in(1'b0, '0, '0, 1'b1, 5'd7, 32'h12, '0, '0);
    cycle();
    chk("byp_we", bus.rf_we, 1);
    chk("byp_wa", bus.rf_wa, 7);
    chk("byp_wd", bus.rf_wd, 32'h12);
    chk("byp_empty", bus.md_ready, 1);
    idle();
    cycle();

    // Contention: WB for three cycles while r8 and r9 queue up
    set_in(1'b1, 5'd1, 32'h101, 1'b1, 5'd8, 32'h88, '0, '0);
    cycle();
    set_in(1'b1, 5'd2, 32'h102, 1'b1, 5'd9, 32'h99, '0, '0);
    cycle();
    chk("full_md_ready", bus.md_ready, 0);
    chk("full_stall", bus.stall_req, 1);
    set_in(1'b1, 5'd3, 32'h103, 1'b0, '0, '0, '0, '0);
    cycle();
    chk("cont_wb3", bus.rf_wa, 3);
    idle();
    cycle();
    chk("drain_r8", bus.rf_wa, 8);
    chk("drain_r8_d", bus.rf_wd, 32'h88);
    cycle();
    chk("drain_r9", bus.rf_wa, 9);
    chk("drain_r9_d", bus.rf_wd, 32'h99);
    cycle();

    // Starvation: one entry held back by continuous WB
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd8, 32'h77, '0, '0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, ADDR_W'(10 + i), DATA_W'(i), 1'b0, '0, '0, '0, '0);
      cycle();
      if (i == 2) chk("starve_early", bus.stall_req, 0);
    end
    chk("starve_stall", bus.stall_req, 1);
    idle();
    cycle();
    chk("starve_wa", bus.rf_wa, 8);
    chk("starve_wd", bus.rf_wd, 32'h77);
    chk("starve_release", bus.stall_req, 0);

    // Hazard tracking of a queued r9
    set_in(1'b1, 5'd4, 32'h4, 1'b1, 5'd9, 32'h909, 5'd9, 5'd0);
    cycle();
    chk("hz_queued", bus.hazard1, 1);
    chk("hz_r0", bus.hazard2, 0);
    set_in(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd0);
    cycle();
    chk("hz_commit_wa", bus.rf_wa, 9);
    chk("hz_at_rf", bus.hazard1, 1);
    cycle();
    chk("hz_cleared", bus.hazard1, 0);

    // Reset in the middle of a full queue
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h8, 5'd8, 5'd9);
    cycle();
    set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 32'h9, 5'd8, 5'd9);
    cycle();
    set_in(1'b0, '0, '0, 1'b0, '0, '0, 5'd8, 5'd9);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", bus.rf_we, 0);
    chk("mid_rst_wa", bus.rf_wa, 0);
    chk("mid_rst_wd", bus.rf_wd, 0);
    chk("mid_rst_ready", bus.md_ready, 1);
    chk("mid_rst_stall", bus.stall_req, 0);
    chk("mid_rst_hz1", bus.hazard1, 0);
    chk("mid_rst_hz2", bus.hazard2, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_we", bus.rf_we, 0);
    end

    // Random traffic obeying the stall protocol
    for (int i = 0; i < 400; i++) begin
      set_in(!last_stall && ($urandom_range(0, 99) < 60),
             ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
             ($urandom_range(0, 99) < 50),
             ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
             ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
